// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared FSM type and constants for the store buffer
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;

  // Entries are tagged with the word address, adr[AW-1:SB_WORD_LSB].
  localparam int SB_WORD_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - store entry queue with youngest-match lookup
// Lookup logic is only built with STORE_BUFFER_FWD_EN defined.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int WAW   = 30,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic [WAW-1:0] push_adr_i,
  input  logic [DW-1:0]  push_data_i,
  input  logic           pop_i,
  output logic [WAW-1:0] head_adr_o,
  output logic [DW-1:0]  head_data_o,
  output logic           full_o,
  output logic           empty_o,
  input  logic [WAW-1:0] lk_adr_i,
  output logic           hit_o,
  output logic [DW-1:0]  hit_data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WAW-1:0] adr_q  [DEPTH];
  logic [DW-1:0]  data_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_ff @(posedge clk) begin
    if (push_i) begin
      adr_q[wr_ptr_q]  <= push_adr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_adr_o  = adr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);

`ifdef STORE_BUFFER_FWD_EN
  // Scan oldest to youngest so the last valid match is the youngest store.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (adr_q[rd_ptr_q + PW'(i)] == lk_adr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[rd_ptr_q + PW'(i)];
      end
    end
  end
`else
  logic unused_lk;
  assign unused_lk  = ^lk_adr_i;
  assign hit_o      = 1'b0;
  assign hit_data_o = '0;
`endif

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer between core and unified memory
// Read-hit forwarding from queued stores is enabled by STORE_BUFFER_FWD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] writedata,
  input  logic          memwrite,
  input  logic          memread,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);
  localparam int WAW = AW - SB_WORD_LSB;

  sb_state_e      state_q, state_d;
  logic [AW-1:0]  mem_adr_q, mem_adr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           mem_we_q, mem_we_d;
  logic           mem_re_q, mem_re_d;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_hit;
  logic [WAW-1:0] fifo_head_adr;
  logic [DW-1:0]  fifo_head_data, fifo_hit_data;
  logic           rd_req, rd_hit, rd_issue, rd_done;

  logic [SB_WORD_LSB-1:0] unused_adr_lsb;
  assign unused_adr_lsb = adr[SB_WORD_LSB-1:0];

  store_buffer_fifo #(
    .DEPTH (DEPTH),
    .WAW   (WAW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fifo_push),
    .push_adr_i  (adr[AW-1:SB_WORD_LSB]),
    .push_data_i (writedata),
    .pop_i       (fifo_pop),
    .head_adr_o  (fifo_head_adr),
    .head_data_o (fifo_head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .lk_adr_i    (adr[AW-1:SB_WORD_LSB]),
    .hit_o       (fifo_hit),
    .hit_data_o  (fifo_hit_data)
  );

  // A simultaneous store takes priority; the read is simply not serviced.
  assign rd_req    = memread && !memwrite;
  assign rd_hit    = rd_req && fifo_hit;
  assign rd_done   = (state_q == ST_READ) && mem_ready;
  assign fifo_push = memwrite && !fifo_full;
  assign fifo_pop  = (state_q == ST_WRITE) && mem_ready;

`ifdef STORE_BUFFER_FWD_EN
  assign rd_issue = rd_req && !fifo_hit;
`else
  // Without forwarding a read may only go to memory once every store has drained.
  assign rd_issue = rd_req && fifo_empty;
`endif

  always_comb begin
    stall    = 1'b0;
    readdata = '0;
    if (memwrite) begin
      stall = fifo_full;
    end else if (memread) begin
      if (rd_hit) begin
        readdata = fifo_hit_data;
      end else if (rd_done) begin
        readdata = mem_rdata;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = mem_re_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_issue) begin
          state_d   = ST_READ;
          mem_re_d  = 1'b1;
          mem_adr_d = adr;
        end else if (!fifo_empty) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_adr_d   = {fifo_head_adr, {SB_WORD_LSB{1'b0}}};
          mem_wdata_d = fifo_head_data;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          state_d  = ST_IDLE;
          mem_we_d = 1'b0;
        end
      end
      ST_READ: begin
        if (mem_ready) begin
          state_d  = ST_IDLE;
          mem_re_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized bench for store_buffer against a queue-based model
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr, writedata, readdata, mem_adr, mem_wdata, mem_rdata;
  logic        memwrite, memread, stall, mem_we, mem_re, mem_ready;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t         mq[$];
  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_arr[mem_adr[7:2]];

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .memread   (memread),
    .readdata  (readdata),
    .stall     (stall),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

`ifdef STORE_BUFFER_FWD_EN
  function automatic logic model_hit(input logic [31:0] a, output logic [31:0] d);
    model_hit = 1'b0;
    d = '0;
    foreach (mq[i]) begin
      if (mq[i].a[31:2] == a[31:2]) begin
        model_hit = 1'b1;
        d = mq[i].d;
      end
    end
  endfunction
`endif

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Samples mid-cycle, checks against the model, then applies what the next edge will do.
  task automatic observe();
    logic full_now;
    @(negedge clk);
    full_now = (mq.size() == DEPTH);
    if (mem_we && mem_re) check("we_re_exclusive", 1, 0);
    if (memwrite) begin
      check("wr_stall", 32'(stall), 32'(full_now));
    end else if (memread) begin
`ifdef STORE_BUFFER_FWD_EN
      begin
        logic        hit;
        logic [31:0] hd;
        hit = model_hit(adr, hd);
        if (hit) begin
          check("hit_stall", 32'(stall), 0);
          check("hit_data", readdata, hd);
          check("hit_no_mem_re", 32'(mem_re), 0);
        end else if (!stall) begin
          check("miss_data", readdata, ref_mem[adr[7:2]]);
          check("miss_mem_re", 32'(mem_re), 1);
        end
      end
`else
      if (!stall) begin
        check("rd_only_when_empty", mq.size(), 0);
        check("rd_data", readdata, ref_mem[adr[7:2]]);
        check("rd_mem_re", 32'(mem_re), 1);
      end
`endif
    end else begin
      check("idle_stall", 32'(stall), 0);
    end
    if (mem_we && mem_ready) begin
      if (mq.size() == 0) begin
        check("drain_unexpected", 1, 0);
      end else begin
        check("drain_adr", mem_adr, mq[0].a);
        check("drain_data", mem_wdata, mq[0].d);
        ref_mem[mq[0].a[7:2]] = mq[0].d;
        void'(mq.pop_front());
      end
      mem_arr[mem_adr[7:2]] = mem_wdata;
    end
    if (memwrite && !stall) mq.push_back(st_t'{a: {adr[31:2], 2'b00}, d: writedata});
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    memwrite  = 1'b0;
    memread   = 1'b0;
    mem_ready = 1'b1;
    while (mq.size() != 0 && k < 60) begin
      observe();
      adv();
      k++;
    end
    check(tag, mq.size(), 0);
  endtask

  initial begin
    int          cnt;
    int          r;
    int          wait_cnt;
    bit          pend;
    logic [31:0] a;

    reset = 1'b0; memwrite = 1'b0; memread = 1'b0; mem_ready = 1'b0;
    adr = '0; writedata = '0;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end

    #12;
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_re", 32'(mem_re), 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_readdata", readdata, 0);
    adv();
    reset = 1'b1;

    // Single store 80 <- 7 with memory always ready.
    memwrite = 1'b1; adr = 32'd80; writedata = 32'd7; mem_ready = 1'b1;
    observe();
    check("st_accept", 32'(stall), 0);
    adv();
    memwrite = 1'b0;
    observe();
    check("st_we_not_yet", 32'(mem_we), 0);
    adv();
    observe();
    check("st_we", 32'(mem_we), 1);
    check("st_adr", mem_adr, 32'd80);
    check("st_data", mem_wdata, 32'd7);
    adv();
    memread = 1'b1; adr = 32'd80;
    observe();
    check("st_we_drop", 32'(mem_we), 0);
    check("empty_read_stall", 32'(stall), 1);
    adv();
    observe();
    check("miss_stall_release", 32'(stall), 0);
    check("miss_re", 32'(mem_re), 1);
    check("miss_readback", readdata, 32'd7);
    adv();
    memread = 1'b0;

    // Fill to DEPTH with memory stalled, then a fifth store.
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      memwrite = 1'b1; adr = 32'(i * 4); writedata = $urandom;
      observe();
      check("fill_accept", 32'(stall), 0);
      adv();
    end
    memwrite = 1'b1; adr = 32'd16; writedata = 32'hCAFE0016;
    observe();
    check("full_stall", 32'(stall), 1);
    check("full_head_we", 32'(mem_we), 1);
    check("full_head_adr", mem_adr, 0);
    adv();
    mem_ready = 1'b1;
    cnt = 0;
    pend = 1'b1;
    while (pend && cnt < 20) begin
      observe();
      if (!stall) pend = 1'b0;
      adv();
      cnt++;
    end
    check("fifth_accepted", 32'(pend), 0);
    drain("full_drain");

    // Two stores to 80 with memory stalled, then a read of 80.
    mem_ready = 1'b0;
    memwrite = 1'b1; adr = 32'd80; writedata = 32'd5;
    observe(); adv();
    writedata = 32'd7;
    observe(); adv();
    memwrite = 1'b0; memread = 1'b1; adr = 32'd80;
    observe();
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_stall", 32'(stall), 0);
    check("fwd_data", readdata, 32'd7);
    check("fwd_no_re", 32'(mem_re), 0);
`else
    check("nofwd_stall", 32'(stall), 1);
`endif
    adv();
    mem_ready = 1'b1;
    cnt = 0;
    observe();
    while (stall && cnt < 30) begin
      adv();
      observe();
      cnt++;
    end
    check("fwd_read_done", 32'(stall), 0);
    check("fwd_read_data", readdata, 32'd7);
    adv();
    drain("fwd_drain");

    // Read miss to 96 while a store to 80 is queued.
    mem_ready = 1'b1;
    memwrite = 1'b1; adr = 32'd80; writedata = 32'd9;
    observe(); adv();
    memwrite = 1'b0; memread = 1'b1; adr = 32'd96;
    observe();
    check("miss96_stall", 32'(stall), 1);
    cnt = 0;
    while (stall && cnt < 30) begin
      adv();
      observe();
      cnt++;
    end
    check("miss96_done", 32'(stall), 0);
    check("miss96_data", readdata, ref_mem[24]);
`ifdef STORE_BUFFER_FWD_EN
    check("miss96_before_drain", mq.size(), 1);
`endif
    adv();
    drain("miss96_drain");

    // Reset asserted while a drain is in progress.
    mem_ready = 1'b0;
    memwrite = 1'b1; adr = 32'd80; writedata = 32'd3;
    observe(); adv();
    memwrite = 1'b0;
    observe(); adv();
    observe();
    check("pre_reset_we", 32'(mem_we), 1);
    #1 reset = 1'b0;
    #1;
    check("reset_we_drop", 32'(mem_we), 0);
    check("reset_adr_clear", mem_adr, 0);
    mq.delete();
    adv();
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      observe();
      check("post_reset_no_we", 32'(mem_we), 0);
      adv();
    end

    // Random traffic over a small address window to provoke hits and full stalls.
    pend = 1'b0;
    wait_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      mem_ready = ($urandom_range(0, 9) < 4);
      if (!pend) begin
        r = $urandom_range(0, 9);
        a = 32'd64 + 32'($urandom_range(0, 7) << 2);
        memwrite = 1'b0;
        memread  = 1'b0;
        if (r < 4) begin
          memwrite = 1'b1; adr = a; writedata = $urandom; pend = 1'b1;
        end else if (r < 7) begin
          memread = 1'b1; adr = a; pend = 1'b1;
        end
      end
      observe();
      if (pend && !stall) begin
        pend = 1'b0;
        wait_cnt = 0;
      end else if (pend) begin
        wait_cnt++;
        if (wait_cnt > 200) begin
          check("req_timeout", 1, 0);
          break;
        end
      end
      adv();
    end
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
